// File: rtl/ddr_cmd_sequencer.sv
// DDR4 command sequencer: turns a 128-bit command stream into per-slot command
// strobes and slot-addressed bank/row/column buses, one registered cycle later.
module ddr_cmd_sequencer #(
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [127:0]           S_AXIS_CMD_tdata,
    input  logic                   S_AXIS_CMD_tvalid,
    output logic                   S_AXIS_CMD_tready,
    output logic [3:0]             ddr_act,
    output logic [3:0]             ddr_read,
    output logic [3:0]             ddr_write,
    output logic [3:0]             ddr_pre,
    output logic [3:0]             ddr_pall,
    output logic [3:0]             ddr_ref,
    output logic [3:0]             ddr_zq,
    output logic [3:0]             ddr_ap,
    output logic [3:0]             ddr_half_bl,
    output logic [3:0]             ddr_nop,
    output logic [4*BG_WIDTH-1:0]  ddr_bg,
    output logic [4*BANK_WIDTH-1:0] ddr_bank,
    output logic [4*COL_WIDTH-1:0] ddr_col,
    output logic [4*ROW_WIDTH-1:0] ddr_row,
    output logic                   busy,
    output logic                   err,
    output logic [31:0]            cmd_count
);

    typedef enum logic {ST_RUN, ST_WAIT} state_e;

    state_e state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] act_q, act_d, rd_q, rd_d, wr_q, wr_d, pre_q, pre_d;
    logic [3:0] pall_q, pall_d, ref_q, ref_d, zq_q, zq_d, ap_q, ap_d, hbl_q, hbl_d;
    logic [4*BG_WIDTH-1:0]   bg_q, bg_d;
    logic [4*BANK_WIDTH-1:0] bank_q, bank_d;
    logic [4*COL_WIDTH-1:0]  col_q, col_d;
    logic [4*ROW_WIDTH-1:0]  row_q, row_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic        tready;
    logic        accept;
    logic [3:0]  opcode;
    logic [1:0]  slot;
    logic [3:0]  onehot;
    logic [31:0] wait_n;
    logic        unused_tdata;

    assign opcode       = S_AXIS_CMD_tdata[127:124];
    assign slot         = S_AXIS_CMD_tdata[123:122];
    assign wait_n       = S_AXIS_CMD_tdata[95:64];
    assign onehot       = 4'b0001 << slot;
    assign accept       = S_AXIS_CMD_tvalid & tready;
    assign unused_tdata = ^S_AXIS_CMD_tdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (accept && opcode == 4'd8 && wait_n != '0) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = wait_n;
                end
            end
            ST_WAIT: begin
                // Loaded with N, leaves on the cycle the count reads 1: exactly N WAIT cycles.
                wait_cnt_d = (wait_cnt_q == '0) ? '0 : wait_cnt_q - 32'd1;
                if (wait_cnt_q <= 32'd1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        tready = en & (state_q == ST_RUN) & ~rst;
        busy   = (state_q == ST_WAIT) | (|(act_q | rd_q | wr_q | pre_q | pall_q | ref_q | zq_q));
    end

    always_comb begin
        act_d  = '0; rd_d  = '0; wr_d  = '0; pre_d = '0; pall_d = '0;
        ref_d  = '0; zq_d  = '0; ap_d  = '0; hbl_d = '0;
        bg_d   = '0; bank_d = '0; col_d = '0; row_d = '0;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (accept) begin
            if (opcode <= 4'd8) cnt_d = cnt_q + 32'd1;
            else                err_d = 1'b1;
            case (opcode)
                4'd1: begin
                    act_d = onehot;
                    bg_d[slot*BG_WIDTH +: BG_WIDTH]       = S_AXIS_CMD_tdata[52 +: BG_WIDTH];
                    bank_d[slot*BANK_WIDTH +: BANK_WIDTH] = S_AXIS_CMD_tdata[48 +: BANK_WIDTH];
                    row_d[slot*ROW_WIDTH +: ROW_WIDTH]    = S_AXIS_CMD_tdata[0 +: ROW_WIDTH];
                end
                4'd2, 4'd3: begin
                    if (opcode == 4'd2) rd_d = onehot;
                    else                wr_d = onehot;
                    ap_d  = S_AXIS_CMD_tdata[121] ? onehot : 4'b0000;
                    hbl_d = S_AXIS_CMD_tdata[120] ? onehot : 4'b0000;
                    bg_d[slot*BG_WIDTH +: BG_WIDTH]       = S_AXIS_CMD_tdata[52 +: BG_WIDTH];
                    bank_d[slot*BANK_WIDTH +: BANK_WIDTH] = S_AXIS_CMD_tdata[48 +: BANK_WIDTH];
                    col_d[slot*COL_WIDTH +: COL_WIDTH]    = S_AXIS_CMD_tdata[32 +: COL_WIDTH];
                end
                4'd4: begin
                    pre_d = onehot;
                    bg_d[slot*BG_WIDTH +: BG_WIDTH]       = S_AXIS_CMD_tdata[52 +: BG_WIDTH];
                    bank_d[slot*BANK_WIDTH +: BANK_WIDTH] = S_AXIS_CMD_tdata[48 +: BANK_WIDTH];
                end
                4'd5: begin
                    pre_d  = onehot;
                    pall_d = onehot;
                end
                4'd6:    ref_d = onehot;
                4'd7:    zq_d  = onehot;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= '0; rd_q <= '0; wr_q <= '0; pre_q <= '0; pall_q <= '0;
            ref_q <= '0; zq_q <= '0; ap_q <= '0; hbl_q <= '0;
            bg_q  <= '0; bank_q <= '0; col_q <= '0; row_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            act_q <= act_d; rd_q <= rd_d; wr_q <= wr_d; pre_q <= pre_d; pall_q <= pall_d;
            ref_q <= ref_d; zq_q <= zq_d; ap_q <= ap_d; hbl_q <= hbl_d;
            bg_q  <= bg_d; bank_q <= bank_d; col_q <= col_d; row_q <= row_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign S_AXIS_CMD_tready = tready;
    assign ddr_act     = act_q;
    assign ddr_read    = rd_q;
    assign ddr_write   = wr_q;
    assign ddr_pre     = pre_q;
    assign ddr_pall    = pall_q;
    assign ddr_ref     = ref_q;
    assign ddr_zq      = zq_q;
    assign ddr_ap      = ap_q;
    assign ddr_half_bl = hbl_q;
    assign ddr_nop     = ~(act_q | rd_q | wr_q | pre_q | pall_q | ref_q | zq_q);
    assign ddr_bg      = bg_q;
    assign ddr_bank    = bank_q;
    assign ddr_col     = col_q;
    assign ddr_row     = row_q;
    assign err         = err_q;
    assign cmd_count   = cnt_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer with hand-computed expectations.
module tb_ddr_cmd_sequencer;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [127:0] tdata;
    logic         tvalid, tready;
    logic [3:0]   act, rd, wr, pre, pall, rf, zq, ap, hbl, nop;
    logic [7:0]   bg, bank;
    logic [39:0]  col;
    logic [67:0]  row;
    logic         busy, err;
    logic [31:0]  cmd_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr_cmd_sequencer #(.BG_WIDTH(2), .BANK_WIDTH(2), .COL_WIDTH(10), .ROW_WIDTH(17)) dut (
        .clk(clk), .rst(rst), .en(en),
        .S_AXIS_CMD_tdata(tdata), .S_AXIS_CMD_tvalid(tvalid), .S_AXIS_CMD_tready(tready),
        .ddr_act(act), .ddr_read(rd), .ddr_write(wr), .ddr_pre(pre), .ddr_pall(pall),
        .ddr_ref(rf), .ddr_zq(zq), .ddr_ap(ap), .ddr_half_bl(hbl), .ddr_nop(nop),
        .ddr_bg(bg), .ddr_bank(bank), .ddr_col(col), .ddr_row(row),
        .busy(busy), .err(err), .cmd_count(cmd_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [3:0] op, input logic [1:0] slot,
                                        input logic apb, input logic hb, input logic [31:0] n,
                                        input logic [3:0] g, input logic [3:0] b,
                                        input logic [15:0] c, input logic [31:0] r);
        logic [127:0] w;
        w = '0;
        w[127:124] = op; w[123:122] = slot; w[121] = apb; w[120] = hb;
        w[95:64] = n; w[55:52] = g; w[51:48] = b; w[47:32] = c; w[31:0] = r;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tvalid = 1'b0; tdata = '0;
        step(); step();
        check("rst_tready", tready, 0);
        check("rst_nop", nop, 4'hF);
        check("rst_count", cmd_count, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0; en = 1'b1; #1;
        check("ready_after_rst", tready, 1);

        // ACT slot 2
        tdata = mk(4'd1, 2'd2, 0, 0, 0, 4'd1, 4'd3, 16'h0, 32'h1ABC); tvalid = 1'b1;
        step(); tvalid = 1'b0;
        check("act_strobe", act, 4'b0100);
        check("act_nop", nop, 4'b1011);
        check("act_row", row, 68'h1ABC << 34);
        check("act_bg", bg, 8'h10);
        check("act_bank", bank, 8'h30);
        check("act_col", col, 0);
        check("act_count", cmd_count, 1);
        check("act_busy", busy, 1);
        step();
        check("act_once", act, 0);
        check("idle_nop", nop, 4'hF);
        check("idle_row", row, 0);
        check("idle_busy", busy, 0);

        // back-to-back ACT / RD / WR / PREA
        tdata = mk(4'd1, 2'd0, 0, 0, 0, 4'd0, 4'd1, 16'h0, 32'h5); tvalid = 1'b1;
        step();
        check("b2b_act", act, 4'b0001);
        check("b2b_ready1", tready, 1);
        tdata = mk(4'd2, 2'd1, 1, 0, 0, 4'd2, 4'd0, 16'h155, 32'h0);
        step();
        check("b2b_rd", rd, 4'b0010);
        check("b2b_rd_ap", ap, 4'b0010);
        check("b2b_rd_hbl", hbl, 0);
        check("b2b_rd_noact", act, 0);
        check("b2b_rd_col", col, 40'h155 << 10);
        check("b2b_rd_bg", bg, 8'h08);
        check("b2b_ready2", tready, 1);
        tdata = mk(4'd3, 2'd3, 0, 1, 0, 4'd0, 4'd0, 16'h0, 32'h0);
        step();
        check("b2b_wr", wr, 4'b1000);
        check("b2b_wr_hbl", hbl, 4'b1000);
        check("b2b_wr_ap", ap, 0);
        check("b2b_wr_nord", rd, 0);
        tdata = mk(4'd5, 2'd1, 1, 1, 0, 4'd0, 4'd0, 16'h0, 32'h0);
        step(); tvalid = 1'b0;
        check("prea_pall", pall, 4'b0010);
        check("prea_pre", pre, 4'b0010);
        check("prea_ap", ap, 0);
        check("prea_nop", nop, 4'b1101);
        step();
        check("b2b_idle", nop, 4'hF);
        check("b2b_count", cmd_count, 5);

        // WAIT N=5 with ACT held valid behind it
        tdata = mk(4'd8, 2'd0, 0, 0, 32'd5, 4'd0, 4'd0, 16'h0, 32'h0); tvalid = 1'b1;
        step();
        tdata = mk(4'd1, 2'd0, 0, 0, 0, 4'd0, 4'd0, 16'h0, 32'h7);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wait_ready_%0d", i), tready, 0);
            check($sformatf("wait_busy_%0d", i), busy, 1);
            check($sformatf("wait_noact_%0d", i), act, 0);
            step();
        end
        check("wait_release", tready, 1);
        check("wait_release_act", act, 0);
        step(); tvalid = 1'b0;
        check("wait_act", act, 4'b0001);
        check("wait_count", cmd_count, 7);

        // illegal opcode then REF
        tdata = mk(4'hC, 2'd0, 0, 0, 0, 4'd0, 4'd0, 16'h0, 32'h0); tvalid = 1'b1;
        step();
        check("ill_err", err, 1);
        check("ill_nop", nop, 4'hF);
        check("ill_count", cmd_count, 7);
        tdata = mk(4'd6, 2'd0, 0, 0, 0, 4'd0, 4'd0, 16'h0, 32'h0);
        step(); tvalid = 1'b0;
        check("ref_strobe", rf, 4'b0001);
        check("ref_count", cmd_count, 8);
        step();
        check("ref_once", rf, 0);
        check("err_sticky", err, 1);

        // WAIT N=0 and NOP: counted, no strobe, no stall
        tdata = mk(4'd8, 2'd0, 0, 0, 32'd0, 4'd0, 4'd0, 16'h0, 32'h0); tvalid = 1'b1;
        step();
        check("wait0_ready", tready, 1);
        check("wait0_busy", busy, 0);
        tdata = mk(4'd0, 2'd2, 0, 0, 0, 4'd0, 4'd0, 16'h0, 32'h0);
        step(); tvalid = 1'b0;
        check("nop_nop", nop, 4'hF);
        check("nop_count", cmd_count, 10);

        // en low holds off acceptance
        en = 1'b0;
        tdata = mk(4'd1, 2'd1, 0, 0, 0, 4'd0, 4'd0, 16'h0, 32'h9); tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("en0_ready_%0d", i), tready, 0);
            step();
            check($sformatf("en0_act_%0d", i), act, 0);
            check($sformatf("en0_nop_%0d", i), nop, 4'hF);
        end
        check("en0_count", cmd_count, 10);
        en = 1'b1; #1;
        check("en1_ready", tready, 1);
        step(); tvalid = 1'b0;
        check("en1_act", act, 4'b0010);
        check("en1_count", cmd_count, 11);

        // reset in the middle of a long WAIT
        tdata = mk(4'd8, 2'd0, 0, 0, 32'd100, 4'd0, 4'd0, 16'h0, 32'h0); tvalid = 1'b1;
        step(); tvalid = 1'b0;
        step(); step();
        check("wait100_busy", busy, 1);
        rst = 1'b1; #1;
        check("rst_hi_ready", tready, 0);
        step();
        check("midrst_busy", busy, 0);
        check("midrst_count", cmd_count, 0);
        check("midrst_err", err, 0);
        check("midrst_nop", nop, 4'hF);
        rst = 1'b0; #1;
        check("midrst_ready", tready, 1);

        // reset beats a simultaneous accept
        tdata = mk(4'd1, 2'd3, 0, 0, 0, 4'd0, 4'd0, 16'h0, 32'h1); tvalid = 1'b1; rst = 1'b1;
        step(); rst = 1'b0; tvalid = 1'b0;
        check("rstacc_act", act, 0);
        check("rstacc_count", cmd_count, 0);
        step();
        check("rstacc_act2", act, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_sequencer.md
DDR_CMD_SEQUENCER -- requirements
Module: ddr_cmd_sequencer

Interface
REQ-001 Parameter BG_WIDTH, default 2: DDR4 bank-group bits per slot.
REQ-002 Parameter BANK_WIDTH, default 2: bank bits per slot.
REQ-003 Parameter COL_WIDTH, default 10: column bits per slot.
REQ-004 Parameter ROW_WIDTH, default 17: row bits per slot.
REQ-005 Port clk, input, 1: single clock (DDR4 user clock); all logic on rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port en, input, 1: sequencing enable (calibration complete).
REQ-008 Ports S_AXIS_CMD_tdata (in, 128), S_AXIS_CMD_tvalid (in, 1), S_AXIS_CMD_tready (out, 1): command stream.
REQ-009 Ports ddr_act, ddr_read, ddr_write, ddr_pre, ddr_pall, ddr_ref, ddr_zq, ddr_ap, ddr_half_bl, ddr_nop, each output, 4: per-slot command strobes, bit i = slot i.
REQ-010 Ports ddr_bg (out, 4*BG_WIDTH), ddr_bank (out, 4*BANK_WIDTH), ddr_col (out, 4*COL_WIDTH), ddr_row (out, 4*ROW_WIDTH): per-slot address, slot i in field i.
REQ-011 Ports busy (out, 1), err (out, 1), cmd_count (out, 32): status.

Function
REQ-012 Command word: opcode [127:124], slot [123:122], ap [121], half_bl [120], wait count [95:64], bg [55:52], bank [51:48], col [47:32], row [31:0]; address fields truncated to parameter widths.
REQ-013 Opcodes: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 ZQ, 8 WAIT; 9-15 illegal.
REQ-014 States: RUN, WAIT; reset enters RUN.
REQ-015 S_AXIS_CMD_tready = en AND state==RUN, combinational from registers and en only (no dependence on tvalid).
REQ-016 Accept = tvalid AND tready; throughput one command per cycle in RUN.
REQ-017 Accepted opcodes 1-7 on cycle t: corresponding strobe bit [slot] asserted in cycle t+1 only, for exactly one cycle (registered outputs, latency 1).
REQ-018 PREA drives ddr_pall[slot] and ddr_pre[slot]; RD/WR drive ddr_ap[slot] and ddr_half_bl[slot] from word bits; other opcodes drive ap/half_bl 0.
REQ-019 Address fields written to slot field [slot] of the relevant bus in the issuing cycle; all other slot fields and all non-issuing cycles drive 0.
REQ-020 ddr_nop = bitwise NOT of OR of all command strobes, per slot; idle cycles drive 4'hF.
REQ-021 Opcode 0: accepted, no strobe, ddr_nop 4'hF next cycle, counted.
REQ-022 Opcode 8 with count N>0: enter WAIT, tready low for exactly N cycles starting cycle t+1, return to RUN so tready may rise in cycle t+N+1; N=0 behaves as NOP.
REQ-023 WAIT counter is 32 bits, decrements once per cycle, no wrap; en deassertion does not pause it.
REQ-024 Illegal opcode: command consumed, no strobe, err set sticky until rst, not counted.
REQ-025 cmd_count increments by 1 per accepted legal command (opcodes 0-8); wraps 0xFFFFFFFF -> 0.
REQ-026 busy = state==WAIT OR any strobe asserted this cycle.
REQ-027 en low in RUN: tready low, no acceptance; any strobe already registered still issues in the following cycle.
REQ-028 tdata sampled only on accept; tdata changes while not accepted have no effect.

Reset
REQ-029 rst high on any edge: state RUN, wait counter 0, all strobes 0, ddr_nop 4'hF, all address buses 0, err 0, cmd_count 0, busy 0; tready 0 while rst high.
REQ-030 rst mid-WAIT or mid-issue aborts: no strobe appears in the cycle after rst; in-flight word discarded.
REQ-031 rst takes priority over simultaneous accept.

Verification
REQ-032 ACT slot 2, bg 1, bank 3, row 0x1ABC, en=1 -> next cycle ddr_act=4'b0100, ddr_nop=4'b1011, ddr_row field 2 = 0x1ABC, others 0, cmd_count=1.
REQ-033 Back-to-back ACT slot0, RD slot1 ap=1, WR slot3 half_bl=1 -> three consecutive cycles of single strobes, ddr_ap=4'b0010 in RD cycle, ddr_half_bl=4'b1000 in WR cycle, tready held 1.
REQ-034 WAIT N=5 then ACT slot0 held valid -> tready low exactly 5 cycles, ACT strobe 7 cycles after WAIT accept, busy high during WAIT.
REQ-035 Opcode 0xC then REF slot0 -> err=1 persistent, cmd_count=1, ddr_ref=4'b0001 once.
REQ-036 en=0 with tvalid=1 for 10 cycles -> tready 0, all strobes 0, ddr_nop 4'hF; en=1 -> accept next edge.
REQ-037 rst pulse 3 cycles into WAIT N=100 -> outputs at reset values, tready high first cycle after rst low with en=1, cmd_count=0.
